param_sync_ram: RTL and testbench
=================================

Name: param_sync_ram

Overview:
- Parametrised single-clock simple-dual-port RAM: one write port, one read port.
- Successor to the fixed 8x32 memory used in the Simulação01 top.
- Generalised in width and depth; adds byte enables, a selectable read-during-write mode, registered reads with a valid flag, and a hardware clear sequencer after reset.
- Drop-in storage for datapath and register-file experiments in later simulations.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 3, address width in bits.
- DEPTH, 8, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- RDW_MODE, 0, same-address read-during-write: 0 = old data (read-first), 1 = new data (write-first).
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear sequencer.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write request.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables; bit k gates wdata[8k+7:8k].
- re  in  1  read request.
- raddr  in  ADDR_W  read address.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  one-cycle pulse qualifying rdata.
- init_busy  out  1  clear sequencer active; port requests ignored.

Behaviour:
- Reset values (async, while rst_n=0): rdata=0, rvalid=0, init_busy=1, clear counter=0, FSM=CLEAR. Array contents are not reset asynchronously.
- FSM states and transitions:
  - CLEAR: each cycle writes INIT_VAL to word[cnt] and increments cnt. When cnt==DEPTH-1 is written, go to READY; init_busy falls on that same edge.
  - The full clear takes exactly DEPTH cycles after rst_n deasserts.
  - READY: normal operation. Stays in READY until the next reset.
- During CLEAR:
  - we and re are ignored: no array update from the port, rvalid stays 0, rdata unchanged.
  - Requests are dropped, not queued.
- Write (READY):
  - On the edge with we=1 and waddr<DEPTH, byte k of word[waddr] takes wdata byte k where be[k]=1; other bytes are unchanged.
  - be=0 gives no change.
  - waddr>=DEPTH is silently ignored.
- Read (READY), latency 1:
  - re=1 at edge N gives rdata=word[raddr] and rvalid=1 after edge N.
  - re=0 at an edge gives rvalid=0 and rdata holds its previous value.
  - raddr>=DEPTH returns rdata=0 with rvalid=1.
- Read-during-write, same address, same edge:
  - RDW_MODE=0: rdata returns the pre-write word.
  - RDW_MODE=1: rdata returns the merged post-write word, byte enables applied.
  - Different addresses never interact.
- Reset mid-operation: any rst_n low pulse immediately clears the outputs and restarts CLEAR from cnt=0. Array contents after the new clear are all INIT_VAL.
- Back-to-back reads and writes are allowed every cycle; no stall or backpressure exists.

Optional Feature:
- Macro: PARAM_SYNC_RAM_OUTREG_EN.
- Defined:
  - Adds a second output register stage: read latency becomes 2.
  - rvalid is delayed with the data.
  - Both stages reset to 0.
  - The in-flight stage is squashed (rvalid=0) while init_busy=1.
  - RDW behaviour is evaluated at the first stage.
- Undefined: latency 1 exactly as above; no extra flops.

Test Plan:
- Clear sequence: DEPTH=8, INIT_VAL=32'hDEADBEEF, release rst_n -> init_busy=1 for exactly 8 cycles, then 0; reads of addresses 0..7 all return DEADBEEF with rvalid pulse one cycle after each re.
- Write/read sweep (mirrors the Simulação01 pattern): after clear, write addr i = 32'h1000_0000+i for i=0..7 with be=4'hF, then read 0..7 -> rdata=1000_0000..1000_0007, 1-cycle latency, rvalid high each cycle.
- Byte enables: word 3 = 32'h11223344, then write 32'hAABBCCDD with be=4'b0101 -> read 3 returns 32'h11BB33DD.
- Read-during-write: word 5 = 32'h0000_0005; same edge we=1, waddr=5, wdata=32'h5555_5555, re=1, raddr=5 -> RDW_MODE=0 returns 00000005; RDW_MODE=1 returns 55555555; next read returns 55555555 in both modes.
- Boundaries: DEPTH=6, ADDR_W=3: write to addr 7 ignored; read addr 7 -> rdata=0, rvalid=1. Request during CLEAR (we=1 at cycle 2) -> no effect and no rvalid.
- Reset mid-operation: assert rst_n=0 asynchronously between edges while rvalid=1 -> rdata=0, rvalid=0, init_busy=1 immediately; after release, previously written words read back as INIT_VAL. Repeat with PARAM_SYNC_RAM_OUTREG_EN defined -> same values with latency 2.

Source files
------------

// File: rtl/param_sync_ram_if.sv
// Bus bundle for param_sync_ram: write port, read port and clear-sequencer status.
// The RAM takes the slave modport; the requester takes master.
interface param_sync_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic                  we;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  re;
    logic [ADDR_W-1:0]     raddr;
    logic [DATA_W-1:0]     rdata;
    logic                  rvalid;
    logic                  init_busy;

    modport master (
        output we, waddr, wdata, be, re, raddr,
        input  rdata, rvalid, init_busy
    );

    modport slave (
        input  we, waddr, wdata, be, re, raddr,
        output rdata, rvalid, init_busy
    );
endinterface

// File: rtl/param_sync_ram.sv
// Single-clock simple-dual-port RAM with byte enables, selectable read-during-write and a post-reset clear sequencer.
// Define PARAM_SYNC_RAM_OUTREG_EN to add a second output register stage (read latency 2).
module param_sync_ram #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 3,
    parameter int                DEPTH    = 8,
    parameter int                RDW_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic             clk,
    input logic             rst_n,
    param_sync_ram_if.slave bus
);
    localparam int                BE_W      = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {CLEAR, READY} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                busy;
    logic                waddr_ok, raddr_ok;
    logic [ADDR_W-1:0]   widx, ridx;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data, merged, rd_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = READY;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        busy     = (state_q == CLEAR);
        waddr_ok = ({1'b0, bus.waddr} < DEPTH_C);
        raddr_ok = ({1'b0, bus.raddr} < DEPTH_C);
        // Out-of-range addresses are steered to word 0 so the array is never indexed past DEPTH.
        widx     = waddr_ok ? bus.waddr : '0;
        ridx     = raddr_ok ? bus.raddr : '0;

        merged = mem_q[widx];
        for (int unsigned k = 0; k < BE_W; k++) begin
            if (bus.be[k]) merged[8*k +: 8] = bus.wdata[8*k +: 8];
        end

        rd_word = raddr_ok ? mem_q[ridx] : '0;
        if ((RDW_MODE == 1) && !busy && bus.we && waddr_ok && (bus.waddr == bus.raddr))
            rd_word = merged;

        wr_en    = busy || (bus.we && waddr_ok);
        wr_addr  = busy ? cnt_q : widx;
        wr_data  = busy ? INIT_VAL : merged;

        rvalid_d = !busy && bus.re;
        rdata_d  = rvalid_d ? rd_word : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

`ifdef PARAM_SYNC_RAM_OUTREG_EN
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic              rvalid2_q, rvalid2_d;

    always_comb begin
        rdata2_d  = rdata_q;
        rvalid2_d = rvalid_q && !busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata2_q  <= '0;
            rvalid2_q <= 1'b0;
        end else begin
            rdata2_q  <= rdata2_d;
            rvalid2_q <= rvalid2_d;
        end
    end

    assign bus.rdata  = rdata2_q;
    assign bus.rvalid = rvalid2_q;
`else
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
`endif

    assign bus.init_busy = busy;
endmodule

// File: tb/tb_param_sync_ram.sv
// Directed bench for param_sync_ram: two instances (DEPTH=8 read-first, DEPTH=6 write-first)
// share one stimulus stream and are checked against hand-derived values.
module tb_param_sync_ram;
`ifdef PARAM_SYNC_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [31:0] INIT_A = 32'hDEAD_BEEF;
    localparam logic [31:0] INIT_B = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, re;
    logic [2:0]  waddr, raddr;
    logic [31:0] wdata;
    logic [3:0]  be;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl_a [8];
    logic [31:0] mdl_b [8];

    param_sync_ram_if #(.DATA_W(32), .ADDR_W(3)) bus_a ();
    param_sync_ram_if #(.DATA_W(32), .ADDR_W(3)) bus_b ();

    assign bus_a.we = we;  assign bus_a.waddr = waddr; assign bus_a.wdata = wdata;
    assign bus_a.be = be;  assign bus_a.re    = re;    assign bus_a.raddr = raddr;
    assign bus_b.we = we;  assign bus_b.waddr = waddr; assign bus_b.wdata = wdata;
    assign bus_b.be = be;  assign bus_b.re    = re;    assign bus_b.raddr = raddr;

    param_sync_ram #(.DATA_W(32), .ADDR_W(3), .DEPTH(8), .RDW_MODE(0), .INIT_VAL(INIT_A))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    param_sync_ram #(.DATA_W(32), .ADDR_W(3), .DEPTH(6), .RDW_MODE(1), .INIT_VAL(INIT_B))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    task automatic model_init();
        for (int i = 0; i < 8; i++) begin
            mdl_a[i] = INIT_A;
            mdl_b[i] = (i < 6) ? INIT_B : 32'h0;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
        we = 1'b1; waddr = a; wdata = d; be = m;
        @(posedge clk); #1;
        we = 1'b0;
        mdl_a[a] = merge(mdl_a[a], d, m);
        if (a < 3'd6) mdl_b[a] = merge(mdl_b[a], d, m);
    endtask

    task automatic rd1(input logic [2:0] a, input logic [31:0] ea, input logic [31:0] eb,
                       input bit hold);
        re = 1'b1; raddr = a;
        @(posedge clk); #1;
        re = 1'b0;
        repeat (LAT - 1) begin @(posedge clk); #1; end
        check($sformatf("rvalid_a@%0d", a), {31'b0, bus_a.rvalid}, 32'd1);
        check($sformatf("rdata_a@%0d", a), bus_a.rdata, ea);
        check($sformatf("rvalid_b@%0d", a), {31'b0, bus_b.rvalid}, 32'd1);
        check($sformatf("rdata_b@%0d", a), bus_b.rdata, eb);
        if (hold) begin
            @(posedge clk); #1;
            check("hold_rvalid_a", {31'b0, bus_a.rvalid}, 32'd0);
            check("hold_rdata_a", bus_a.rdata, ea);
            check("hold_rvalid_b", {31'b0, bus_b.rvalid}, 32'd0);
            check("hold_rdata_b", bus_b.rdata, eb);
        end
    endtask

    // Back-to-back reads of 0..7, one per cycle; expected data come from the bench model.
    task automatic rd_burst(input string tag);
        int j;
        for (int i = 0; i < 8 + LAT - 1; i++) begin
            re = (i < 8); raddr = 3'(i);
            @(posedge clk); #1;
            j = i - LAT + 1;
            if (j >= 0) begin
                check($sformatf("%s_rvalid_a[%0d]", tag, j), {31'b0, bus_a.rvalid}, 32'd1);
                check($sformatf("%s_rdata_a[%0d]", tag, j), bus_a.rdata, mdl_a[j]);
                check($sformatf("%s_rvalid_b[%0d]", tag, j), {31'b0, bus_b.rvalid}, 32'd1);
                check($sformatf("%s_rdata_b[%0d]", tag, j), bus_b.rdata, mdl_b[j]);
            end
        end
        re = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        we = 1'b0; re = 1'b0; waddr = '0; raddr = '0; wdata = '0; be = '0;
        model_init();
        #1 rst_n = 1'b0;
        #2;
        check("rst_rdata_a", bus_a.rdata, 32'h0);
        check("rst_rvalid_a", {31'b0, bus_a.rvalid}, 32'd0);
        check("rst_busy_a", {31'b0, bus_a.init_busy}, 32'd1);
        check("rst_rdata_b", bus_b.rdata, 32'h0);
        check("rst_busy_b", {31'b0, bus_b.init_busy}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Clear phase: busy lasts DEPTH edges; a request at edge 2 must be dropped.
        for (int c = 1; c <= 8; c++) begin
            we = (c == 2); re = (c == 2); waddr = 3'd0; raddr = 3'd0;
            wdata = 32'h1234_5678; be = 4'hF;
            @(posedge clk); #1;
            check($sformatf("clr_busy_a[%0d]", c), {31'b0, bus_a.init_busy}, (c < 8) ? 32'd1 : 32'd0);
            check($sformatf("clr_busy_b[%0d]", c), {31'b0, bus_b.init_busy}, (c < 6) ? 32'd1 : 32'd0);
            check($sformatf("clr_rvalid_a[%0d]", c), {31'b0, bus_a.rvalid}, 32'd0);
            check($sformatf("clr_rvalid_b[%0d]", c), {31'b0, bus_b.rvalid}, 32'd0);
        end
        we = 1'b0; re = 1'b0;
        rd_burst("init");

        for (int i = 0; i < 8; i++) wr(3'(i), 32'h1000_0000 + i, 4'hF);
        rd_burst("sweep");

        wr(3'd1, 32'hFFFF_FFFF, 4'h0);
        rd1(3'd1, 32'h1000_0001, 32'h1000_0001, 1'b1);

        wr(3'd3, 32'h1122_3344, 4'hF);
        wr(3'd3, 32'hAABB_CCDD, 4'b0101);
        rd1(3'd3, 32'h11BB_33DD, 32'h11BB_33DD, 1'b1);

        // Same-address read-during-write: A returns old word, B returns merged new word.
        wr(3'd5, 32'h0000_0005, 4'hF);
        we = 1'b1; waddr = 3'd5; wdata = 32'h5555_5555; be = 4'hF; re = 1'b1; raddr = 3'd5;
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
        repeat (LAT - 1) begin @(posedge clk); #1; end
        check("rdw_rvalid_a", {31'b0, bus_a.rvalid}, 32'd1);
        check("rdw_rdata_a", bus_a.rdata, 32'h0000_0005);
        check("rdw_rvalid_b", {31'b0, bus_b.rvalid}, 32'd1);
        check("rdw_rdata_b", bus_b.rdata, 32'h5555_5555);
        mdl_a[5] = 32'h5555_5555; mdl_b[5] = 32'h5555_5555;
        rd1(3'd5, 32'h5555_5555, 32'h5555_5555, 1'b0);

        // Different addresses on the same edge do not interact.
        we = 1'b1; waddr = 3'd2; wdata = 32'h2222_2222; be = 4'hF; re = 1'b1; raddr = 3'd4;
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
        repeat (LAT - 1) begin @(posedge clk); #1; end
        check("diff_rdata_a", bus_a.rdata, 32'h1000_0004);
        check("diff_rdata_b", bus_b.rdata, 32'h1000_0004);
        rd1(3'd2, 32'h2222_2222, 32'h2222_2222, 1'b0);

        // Address 7 is out of range for the DEPTH=6 instance only.
        wr(3'd7, 32'h7777_7777, 4'hF);
        rd1(3'd7, 32'h7777_7777, 32'h0, 1'b1);

        rd1(3'd3, 32'h11BB_33DD, 32'h11BB_33DD, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rdata_a", bus_a.rdata, 32'h0);
        check("mid_rvalid_a", {31'b0, bus_a.rvalid}, 32'd0);
        check("mid_busy_a", {31'b0, bus_a.init_busy}, 32'd1);
        check("mid_rdata_b", bus_b.rdata, 32'h0);
        check("mid_rvalid_b", {31'b0, bus_b.rvalid}, 32'd0);
        check("mid_busy_b", {31'b0, bus_b.init_busy}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("reclr_busy_a", {31'b0, bus_a.init_busy}, 32'd0);
        model_init();
        rd_burst("reclr");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
